// File: rtl/wb_pkg.sv
// Shared types for the Wishbone burst master: FSM state encoding and
// response status fields.
package wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        STROBE,
        RESP,
        DRAIN
    } state_t;

    typedef struct packed {
        logic last;
        logic timeout;
    } rsp_status_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts strobe cycles that go unacknowledged; hit flags the final allowed cycle.
// A TIMEOUT of 0 removes the counter entirely and never signals hit.
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    if (TIMEOUT == 0) begin : g_off
        assign hit = 1'b0;
    end else begin : g_on
        localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
        localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

        logic [CNT_W-1:0] count;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count + CNT_W'(1);
            end
        end

        // Asserted during the TIMEOUT-th waiting cycle so the abort lands right after it.
        assign hit = enable && (count == LAST);
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: one command runs 1..2^LEN_W incrementing
// beats under a single cyc, with per-beat read responses and timeout abort.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [STRB_W-1:0] cmd_sel,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [STRB_W-1:0] wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        rsp_status_t       status;
    } rsp_t;

    state_t           state;
    rsp_t             rsp;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] drain_left;
    logic             last_beat;
    logic             tmo_hit;

    assign last_beat   = (beat == len);
    assign rsp_data    = rsp.data;
    assign rsp_last    = rsp.status.last;
    assign rsp_timeout = rsp.status.timeout;

    wb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (state != STROBE),
        .enable((state == STROBE) && !wb_ack_i),
        .hit   (tmo_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            wr_ready   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp        <= '0;
            busy       <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
            len        <= '0;
            beat       <= '0;
            drain_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        wb_adr_o   <= cmd_addr;
                        wb_sel_o   <= cmd_sel;
                        wb_we_o    <= cmd_we;
                        len        <= cmd_len;
                        beat       <= '0;
                        drain_left <= '0;
                        if (cmd_we) begin
                            wr_ready <= 1'b1;
                            state    <= WDATA;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= STROBE;
                        end
                    end
                end
                WDATA: begin
                    if (wr_valid) begin
                        wr_ready <= 1'b0;
                        wb_dat_o <= wr_data;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    if (wb_ack_i) begin
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) begin
                            rsp.data   <= wb_dat_i;
                            rsp.status <= '{last: last_beat, timeout: 1'b0};
                            rsp_valid  <= 1'b1;
                            wb_cyc_o   <= !last_beat;
                            state      <= RESP;
                        end else if (!last_beat) begin
                            wb_adr_o <= wb_adr_o + ADDR_W'(STRB_W);
                            beat     <= beat + LEN_W'(1);
                            wr_ready <= 1'b1;
                            state    <= WDATA;
                        end else begin
                            rsp.data   <= '0;
                            rsp.status <= '{last: 1'b1, timeout: 1'b0};
                            rsp_valid  <= 1'b1;
                            wb_cyc_o   <= 1'b0;
                            state      <= RESP;
                        end
                    end else if (tmo_hit) begin
                        wb_stb_o   <= 1'b0;
                        wb_cyc_o   <= 1'b0;
                        rsp.data   <= '0;
                        rsp.status <= '{last: 1'b1, timeout: 1'b1};
                        rsp_valid  <= 1'b1;
                        // Beats already accepted are beat+1; the rest must still be consumed.
                        drain_left <= wb_we_o ? (len - beat) : '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp.status <= '0;
                        if (rsp.status.last) begin
                            wb_cyc_o <= 1'b0;
                            if (drain_left != '0) begin
                                wr_ready <= 1'b1;
                                state    <= DRAIN;
                            end else begin
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            wb_adr_o <= wb_adr_o + ADDR_W'(STRB_W);
                            beat     <= beat + LEN_W'(1);
                            wb_stb_o <= 1'b1;
                            state    <= STROBE;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_valid) begin
                        drain_left <= drain_left - LEN_W'(1);
                        if (drain_left == LEN_W'(1)) begin
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master against a transaction-level model of
// Wishbone beats, responses and a word-addressed slave memory.
module tb_wb_burst_master;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned LW  = 4;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_timeout, busy;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o, wb_stb_o, wb_cyc_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_timeout(rsp_timeout), .busy(busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        acked;
        logic [7:0]  cycles;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        tmo;
    } exp_rsp_t;

    logic [31:0] slave_mem [0:16383];
    logic [31:0] model_mem [0:16383];
    bus_t        slave_log[$];
    int unsigned slave_dly[$];
    bus_t        exp_bus[$];
    exp_rsp_t    exp_rsp[$];
    int unsigned cmd_dly[$];
    logic [31:0] cmd_wd[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Slave: ack arrives after the programmed number of extra wait cycles (>= TMO never acks).
    initial begin : slave_proc
        bit          active;
        int unsigned dly, cnt;
        bus_t        cur;
        active = 0; dly = 0; cnt = 0; cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                wb_ack_i = 1'b0;
                active   = 0;
            end else if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                active   = 0;
                wb_dat_i = $urandom;
            end else if (wb_stb_o && wb_cyc_o) begin
                if (!active) begin
                    active  = 1;
                    cnt     = 0;
                    dly     = (slave_dly.size() != 0) ? slave_dly.pop_front() : 0;
                    cur.adr = wb_adr_o;
                    cur.we  = wb_we_o;
                    cur.dat = wb_we_o ? wb_dat_o : 32'h0;
                    cur.sel = wb_sel_o;
                end
                cnt++;
                if (cnt == dly + 1) begin
                    wb_ack_i = 1'b1;
                    if (cur.we) slave_mem[cur.adr[15:2]] = merge(slave_mem[cur.adr[15:2]], cur.dat, cur.sel);
                    else        wb_dat_i = slave_mem[cur.adr[15:2]];
                    cur.acked  = 1'b1;
                    cur.cycles = 8'(cnt);
                    slave_log.push_back(cur);
                end else begin
                    wb_dat_i = $urandom;
                end
            end else begin
                if (active) begin
                    cur.acked  = 1'b0;
                    cur.cycles = 8'(cnt);
                    slave_log.push_back(cur);
                    active = 0;
                end
                wb_dat_i = $urandom;
            end
        end
    end

    int unsigned cyc_rises = 0;
    int unsigned bus_viol  = 0;
    bit          mon_en    = 1;
    logic        prev_cyc  = 1'b0;

    initial begin : bus_monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_cyc_o && !prev_cyc) cyc_rises++;
                if (wb_stb_o && (!wb_cyc_o || rsp_valid)) bus_viol++;
            end
            prev_cyc = wb_cyc_o;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one command to completion; call right after a falling clock edge.
    task automatic run_cmd(input string name, input logic we, input logic [15:0] addr,
                           input logic [3:0] sel, input int unsigned len, input int unsigned stall);
        logic [15:0] a;
        int unsigned d, n_c, n_w, n_r, n_i, idle, stall_left, got_rsp, exp_cnt, wr_left, wr_viol;
        bit          abort, cmd_ok, wr_ok, rsp_ok, done;
        bus_t        b;
        exp_rsp_t    e;

        exp_bus.delete(); exp_rsp.delete(); slave_log.delete(); slave_dly.delete();
        abort = 0;
        for (int unsigned i = 0; i <= len; i++) begin
            a = addr + 16'(4 * i);
            d = (i < cmd_dly.size()) ? cmd_dly[i] : 0;
            slave_dly.push_back(d);
            b.adr    = a;
            b.we     = we;
            b.dat    = we ? cmd_wd[i] : 32'h0;
            b.sel    = sel;
            b.acked  = (d < TMO);
            b.cycles = b.acked ? 8'(d + 1) : 8'(TMO);
            exp_bus.push_back(b);
            if (!b.acked) begin
                exp_rsp.push_back('{32'h0, 1'b1, 1'b1});
                abort = 1;
                break;
            end
            if (we) model_mem[a[15:2]] = merge(model_mem[a[15:2]], cmd_wd[i], sel);
            else    exp_rsp.push_back('{model_mem[a[15:2]], (i == len), 1'b0});
        end
        if (we && !abort) exp_rsp.push_back('{32'h0, 1'b1, 1'b0});

        exp_cnt   = exp_rsp.size();
        got_rsp   = 0;
        wr_left   = we ? len + 1 : 0;
        wr_viol   = 0;
        cyc_rises = 0;
        bus_viol  = 0;
        cmd_ok = 1; wr_ok = 1; rsp_ok = 1;

        fork
            begin : drv_cmd
                cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_sel = sel; cmd_len = LW'(len);
                n_c = 0;
                while (!cmd_ready && n_c < 1000) begin @(negedge clk); n_c++; end
                if (n_c >= 1000) cmd_ok = 0;
                @(negedge clk);
                cmd_valid = 1'b0;
                if (cmd_ok) check({name, "_busy"}, busy, 1);
            end
            begin : drv_wr
                while (wr_left != 0 && wr_ok) begin
                    idle = $urandom_range(0, 2);
                    repeat (idle) @(negedge clk);
                    wr_valid = 1'b1;
                    wr_data  = cmd_wd[len + 1 - wr_left];
                    n_w = 0;
                    while (!wr_ready && n_w < 1000) begin @(negedge clk); n_w++; end
                    if (n_w >= 1000) wr_ok = 0;
                    else if (cmd_ready) wr_viol++;
                    @(negedge clk);
                    wr_valid = 1'b0;
                    if (wr_ok) wr_left--;
                end
            end
            begin : drv_rsp
                done = 0; n_r = 0; stall_left = stall;
                while (!done && n_r < 3000) begin
                    if (rsp_valid && stall_left > 0) begin
                        rsp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (rsp_valid && rsp_ready) begin
                        got_rsp++;
                        if (exp_rsp.size() != 0) begin
                            e = exp_rsp.pop_front();
                            if (!e.tmo) check({name, "_rsp_data"}, rsp_data, e.data);
                            check({name, "_rsp_flags"}, {rsp_last, rsp_timeout}, {e.last, e.tmo});
                        end
                        if (rsp_last) done = 1;
                    end
                    @(negedge clk);
                    n_r++;
                end
                if (!done) rsp_ok = 0;
                rsp_ready = 1'b0;
            end
        join

        n_i = 0;
        while (!cmd_ready && n_i < 100) begin @(negedge clk); n_i++; end
        check({name, "_done"}, {cmd_ok, wr_ok, rsp_ok, cmd_ready}, 4'b1111);
        check({name, "_idle"}, {busy, wb_cyc_o, wb_stb_o, rsp_valid, wr_ready}, 5'b0);
        check({name, "_rsp_count"}, got_rsp, exp_cnt);
        check({name, "_wr_left"}, wr_left, 0);
        check({name, "_drain_before_ready"}, wr_viol, 0);
        check({name, "_cyc_windows"}, cyc_rises, 1);
        check({name, "_bus_rules"}, bus_viol, 0);
        check({name, "_beats"}, slave_log.size(), exp_bus.size());
        for (int unsigned i = 0; i < slave_log.size() && i < exp_bus.size(); i++) begin
            check({name, "_adr"}, slave_log[i].adr, exp_bus[i].adr);
            check({name, "_dat"}, slave_log[i].dat, exp_bus[i].dat);
            check({name, "_ctl"}, {slave_log[i].we, slave_log[i].sel, slave_log[i].acked, slave_log[i].cycles},
                  {exp_bus[i].we, exp_bus[i].sel, exp_bus[i].acked, exp_bus[i].cycles});
        end
    endtask

    initial begin : main
        logic [31:0] v;
        int unsigned n, rsp_cnt, r, len;
        logic        we;

        for (int i = 0; i < 16384; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            model_mem[i] = v;
        end
        slave_mem[16'h0010 >> 2] = 32'hDEADBEEF;
        model_mem[16'h0010 >> 2] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_ctl", {wr_ready, rsp_valid, rsp_last, rsp_timeout, busy, wb_cyc_o, wb_stb_o, wb_we_o}, 8'h0);
        check("reset_bus", {wb_adr_o, wb_dat_o, wb_sel_o, rsp_data}, '0);
        reset = 1'b1;
        @(negedge clk);

        cmd_dly = '{1};      cmd_wd.delete();
        run_cmd("rd_single", 1'b0, 16'h0010, 4'hF, 0, 0);

        cmd_dly = '{0, 1, 0, 2};
        cmd_wd  = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_cmd("wr_burst", 1'b1, 16'h0100, 4'hF, 3, 0);

        cmd_dly = '{0, 0, 0, 0}; cmd_wd.delete();
        run_cmd("rd_back", 1'b0, 16'h0100, 4'hF, 3, 0);

        cmd_dly = '{0, 1};
        run_cmd("rd_stall", 1'b0, 16'h0200, 4'hF, 1, 5);

        cmd_dly = '{255};
        run_cmd("rd_timeout", 1'b0, 16'h0300, 4'hF, 0, 0);

        cmd_dly = '{0, 255, 0, 0};
        cmd_wd  = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
        run_cmd("wr_abort", 1'b1, 16'h0400, 4'h5, 3, 0);

        cmd_dly = '{0, 0}; cmd_wd.delete();
        run_cmd("rd_wrap", 1'b0, 16'hFFFC, 4'hF, 1, 0);

        cmd_dly = '{7};
        run_cmd("rd_race", 1'b0, 16'h0500, 4'hF, 0, 0);

        cmd_dly = '{0, 7};
        cmd_wd  = '{32'h01234567, 32'h89ABCDEF};
        run_cmd("wr_race", 1'b1, 16'hFFFC, 4'h9, 1, 0);

        for (int k = 0; k < 40; k++) begin
            we  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 7);
            cmd_dly.delete(); cmd_wd.delete();
            for (int unsigned i = 0; i <= len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 80)      cmd_dly.push_back($urandom_range(0, 3));
                else if (r < 88) cmd_dly.push_back(7);
                else if (r < 94) cmd_dly.push_back(8);
                else             cmd_dly.push_back(255);
                cmd_wd.push_back($urandom);
            end
            run_cmd(we ? "rnd_wr" : "rnd_rd", we, 16'($urandom) & 16'hFFFC,
                    4'($urandom_range(1, 15)), len, $urandom_range(0, 3));
        end

        // Reset while the second beat of a read burst is strobing.
        mon_en = 0;
        slave_log.delete(); slave_dly.delete();
        slave_dly.push_back(0); slave_dly.push_back(255);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0600; cmd_sel = 4'hF; cmd_len = LW'(3);
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(slave_dly.size() == 0 && wb_stb_o) && n < 200) begin @(negedge clk); n++; end
        check("rstmid_reached_beat2", {slave_log.size() == 1, wb_stb_o}, 2'b11);
        reset = 1'b0;
        #1;
        check("rstmid_bus_drop", {wb_cyc_o, wb_stb_o, rsp_valid, busy}, 4'b0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rsp_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o) rsp_cnt++;
        end
        rsp_ready = 1'b0;
        check("rstmid_no_rsp", rsp_cnt, 0);
        check("rstmid_after_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
